// File: rtl/rdi_sb_pkg.sv
// Shared RDI sideband package.
// Holds the message encodings exchanged between the TX/RX bring-up blocks
// and the sideband TX arbiter, plus the arbiter's state/grant types and
// its starvation-guard helper.
package rdi_sb_pkg;

  localparam int MSG_W = 4;

  // Requests originate in TX bring-up; responses originate in RX bring-up.
  localparam logic [MSG_W-1:0] ACTIVE_REQ    = 4'd1;
  localparam logic [MSG_W-1:0] ACTIVE_RSP    = 4'd2;
  localparam logic [MSG_W-1:0] LINKRESET_REQ = 4'd7;
  localparam logic [MSG_W-1:0] LINKRESET_RSP = 4'd8;
  localparam logic [MSG_W-1:0] LINKERROR_REQ = 4'd9;
  localparam logic [MSG_W-1:0] LINKERROR_RSP = 4'd10;
  localparam logic [MSG_W-1:0] RETRAIN_REQ   = 4'd11;
  localparam logic [MSG_W-1:0] RETRAIN_RSP   = 4'd12;
  localparam logic [MSG_W-1:0] DISABLE_REQ   = 4'd13;
  localparam logic [MSG_W-1:0] DISABLE_RSP   = 4'd14;

  // Number of back-to-back response grants after which a waiting request wins.
  localparam logic [1:0] GUARD_LIMIT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_REQ = 1'b0,
    GNT_RSP = 1'b1
  } grant_e;

  // Responses normally win; a pending request is forced through once the
  // guard counter shows two consecutive response grants.
  function automatic logic pick_req(input logic req_pending,
                                    input logic rsp_pending,
                                    input logic [1:0] guard);
    return req_pending && (!rsp_pending || (guard >= GUARD_LIMIT));
  endfunction

endpackage

// File: rtl/rdi_sb_msg_fifo.sv
// Small message FIFO for one sideband source.
// Ports:
//   lclk, sys_rst      clock, asynchronous active-low reset
//   push, push_msg     write strobe and payload (accepted when not full,
//                      or when full and popped in the same cycle)
//   pop                remove head (ignored when empty)
//   full, empty        occupancy flags, decoded from the pointer registers
//   head               oldest entry
module rdi_sb_msg_fifo
  import rdi_sb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             lclk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [MSG_W-1:0] push_msg,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [MSG_W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [MSG_W-1:0] mem [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is data only; occupancy is tracked by the pointers.
  always_ff @(posedge lclk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_msg;
  end

endmodule

// File: rtl/rdi_sb_tx_arbiter.sv
// Sideband TX arbiter: queues bring-up requests and responses and sends
// them one at a time over the sideband link.
// Ports:
//   lclk, sys_rst            clock, asynchronous active-low reset
//   i_req_msg/i_req_valid    request push from TX bring-up (msg 0 ignored)
//   i_rsp_msg/i_rsp_valid    response push from RX bring-up (msg 0 ignored)
//   o_sb_msg/o_sb_valid      message to the sideband link, 0 when not valid
//   i_sb_ready               link accepts the presented message
//   o_req_done/o_rsp_done    one-cycle pulse after a request/response handshake
//   o_tx_busy                request queued or in flight
//   o_overflow               sticky: a push was dropped on a full queue
module rdi_sb_tx_arbiter
  import rdi_sb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             lclk,
  input  logic             sys_rst,
  input  logic [MSG_W-1:0] i_req_msg,
  input  logic             i_req_valid,
  input  logic [MSG_W-1:0] i_rsp_msg,
  input  logic             i_rsp_valid,
  output logic [MSG_W-1:0] o_sb_msg,
  output logic             o_sb_valid,
  input  logic             i_sb_ready,
  output logic             o_req_done,
  output logic             o_rsp_done,
  output logic             o_tx_busy,
  output logic             o_overflow
);

  arb_state_e       state_q, state_d;
  grant_e           grant_q, grant_d;
  logic [1:0]       guard_q, guard_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             overflow_q;

  logic             req_push, rsp_push;
  logic             req_pop, rsp_pop;
  logic             req_full, rsp_full;
  logic             req_empty, rsp_empty;
  logic [MSG_W-1:0] req_head, rsp_head;
  logic             handshake;

  assign req_push  = i_req_valid && (i_req_msg != '0);
  assign rsp_push  = i_rsp_valid && (i_rsp_msg != '0);
  assign handshake = (state_q == ST_SEND) && i_sb_ready;
  // The queue is popped only on handshake, so the head stays in place while
  // the latched copy is presented to the link.
  assign req_pop   = handshake && (grant_q == GNT_REQ);
  assign rsp_pop   = handshake && (grant_q == GNT_RSP);

  rdi_sb_msg_fifo #(.DEPTH(DEPTH)) u_req_fifo (
    .lclk     (lclk),
    .sys_rst  (sys_rst),
    .push     (req_push),
    .push_msg (i_req_msg),
    .pop      (req_pop),
    .full     (req_full),
    .empty    (req_empty),
    .head     (req_head)
  );

  rdi_sb_msg_fifo #(.DEPTH(DEPTH)) u_rsp_fifo (
    .lclk     (lclk),
    .sys_rst  (sys_rst),
    .push     (rsp_push),
    .push_msg (i_rsp_msg),
    .pop      (rsp_pop),
    .full     (rsp_full),
    .empty    (rsp_empty),
    .head     (rsp_head)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    guard_d = guard_q;
    msg_d   = msg_q;
    case (state_q)
      ST_IDLE: begin
        if (!req_empty || !rsp_empty) begin
          state_d = ST_SEND;
          if (pick_req(!req_empty, !rsp_empty, guard_q)) begin
            grant_d = GNT_REQ;
            msg_d   = req_head;
            guard_d = '0;
          end else begin
            grant_d = GNT_RSP;
            msg_d   = rsp_head;
            guard_d = (guard_q < GUARD_LIMIT) ? guard_q + 2'd1 : guard_q;
          end
        end
      end
      ST_SEND: begin
        if (i_sb_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge lclk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= GNT_RSP;
      guard_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      guard_q    <= guard_d;
      overflow_q <= overflow_q
                    | (req_push && req_full && !req_pop)
                    | (rsp_push && rsp_full && !rsp_pop);
    end
  end

  // Latched message is only observed through the SEND-state gate below.
  always_ff @(posedge lclk) begin
    msg_q <= msg_d;
  end

  // All outputs decode registered state, so an asynchronous reset clears
  // them immediately.
  assign o_sb_valid = (state_q == ST_SEND);
  assign o_sb_msg   = (state_q == ST_SEND) ? msg_q : '0;
  assign o_req_done = (state_q == ST_DONE) && (grant_q == GNT_REQ);
  assign o_rsp_done = (state_q == ST_DONE) && (grant_q == GNT_RSP);
  assign o_tx_busy  = !req_empty
                      || (((state_q == ST_SEND) || (state_q == ST_DONE)) && (grant_q == GNT_REQ));
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_rdi_sb_tx_arbiter.sv
// Bench for rdi_sb_tx_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based transaction model.
module tb_rdi_sb_tx_arbiter;
  import rdi_sb_pkg::*;

  localparam int DEPTH = 2;

  logic       lclk = 1'b0;
  logic       sys_rst;
  logic [3:0] i_req_msg, i_rsp_msg, o_sb_msg;
  logic       i_req_valid, i_rsp_valid, i_sb_ready;
  logic       o_sb_valid, o_req_done, o_rsp_done, o_tx_busy, o_overflow;

  always #5 lclk = ~lclk;

  rdi_sb_tx_arbiter #(.DEPTH(DEPTH)) dut (
    .lclk        (lclk),
    .sys_rst     (sys_rst),
    .i_req_msg   (i_req_msg),
    .i_req_valid (i_req_valid),
    .i_rsp_msg   (i_rsp_msg),
    .i_rsp_valid (i_rsp_valid),
    .o_sb_msg    (o_sb_msg),
    .o_sb_valid  (o_sb_valid),
    .i_sb_ready  (i_sb_ready),
    .o_req_done  (o_req_done),
    .o_rsp_done  (o_rsp_done),
    .o_tx_busy   (o_tx_busy),
    .o_overflow  (o_overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_%0d", tag, i), got[i], exp[i]);
  endtask

  // ---------------- transaction model ----------------
  // Two message queues, one in-flight slot and a one-cycle settle window
  // after each handshake (done cycle) before the next grant may be made.
  int m_rq[$];
  int m_sq[$];
  bit m_fl;
  int m_msg;
  bit m_src_req;
  int m_settle;
  bit m_last_req;
  int m_rsp_run;
  bit m_ovf;

  // Observations of the DUT for directed scenario checks.
  int hs_msg[$];
  int hs_cyc[$];
  int done_log[$];

  task automatic model_reset();
    m_rq.delete();
    m_sq.delete();
    m_fl = 0; m_msg = 0; m_src_req = 0; m_settle = 0;
    m_last_req = 0; m_rsp_run = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit vq, input int mq, input bit vs, input int ms, input bit rdy);
    bit pop_q = 0;
    bit pop_s = 0;
    if (m_fl) begin
      if (rdy) begin
        pop_q = m_src_req;
        pop_s = !m_src_req;
        m_last_req = m_src_req;
        m_fl = 0;
        m_settle = 1;
      end
    end else if (m_settle > 0) begin
      m_settle = 0;
    end else if (m_rq.size() > 0 || m_sq.size() > 0) begin
      m_fl = 1;
      if (m_rq.size() > 0 && (m_sq.size() == 0 || m_rsp_run >= 2)) begin
        m_src_req = 1; m_msg = m_rq[0]; m_rsp_run = 0;
      end else begin
        m_src_req = 0; m_msg = m_sq[0]; m_rsp_run++;
      end
    end
    if (pop_q) void'(m_rq.pop_front());
    if (pop_s) void'(m_sq.pop_front());
    if (vq && mq != 0) begin
      if (m_rq.size() < DEPTH) m_rq.push_back(mq); else m_ovf = 1;
    end
    if (vs && ms != 0) begin
      if (m_sq.size() < DEPTH) m_sq.push_back(ms); else m_ovf = 1;
    end
  endtask

  task automatic compare_outputs();
    bit done_now = (m_settle == 1);
    chk("valid",    o_sb_valid, m_fl);
    chk("msg",      o_sb_msg,   m_fl ? m_msg : 0);
    chk("req_done", o_req_done, done_now && m_last_req);
    chk("rsp_done", o_rsp_done, done_now && !m_last_req);
    chk("busy",     o_tx_busy,  (m_rq.size() > 0) || (m_fl && m_src_req) || (done_now && m_last_req));
    chk("overflow", o_overflow, m_ovf);
  endtask

  // One clock: drive at negedge, advance model at posedge, check at negedge.
  task automatic cycle(input bit vq, input int mq, input bit vs, input int ms, input bit rdy);
    i_req_valid = vq; i_req_msg = 4'(mq);
    i_rsp_valid = vs; i_rsp_msg = 4'(ms);
    i_sb_ready  = rdy;
    if (o_sb_valid && rdy) begin
      hs_msg.push_back(o_sb_msg);
      hs_cyc.push_back(cyc);
    end
    @(posedge lclk);
    cyc++;
    model_edge(vq, mq, vs, ms, rdy);
    @(negedge lclk);
    if (o_req_done) done_log.push_back(1);
    if (o_rsp_done) done_log.push_back(2);
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, rdy);
  endtask

  task automatic clear_logs();
    hs_msg.delete(); hs_cyc.delete(); done_log.delete();
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    i_req_valid = 0; i_req_msg = 0; i_rsp_valid = 0; i_rsp_msg = 0; i_sb_ready = 0;
    model_reset();
    #1;
    chk("rst_valid",    o_sb_valid, 0);
    chk("rst_msg",      o_sb_msg,   0);
    chk("rst_req_done", o_req_done, 0);
    chk("rst_rsp_done", o_rsp_done, 0);
    chk("rst_busy",     o_tx_busy,  0);
    chk("rst_overflow", o_overflow, 0);
    @(negedge lclk);
    @(negedge lclk);
    sys_rst = 1'b1;
    cyc = 0;
    clear_logs();
  endtask

  int req_tab[6] = '{1, 7, 9, 11, 13, 0};
  int rsp_tab[6] = '{2, 8, 10, 12, 14, 0};

  initial begin
    @(negedge lclk);
    do_reset();

    // Single response, link always ready.
    cycle(0, 0, 1, ACTIVE_RSP, 1);
    idle(6, 1);
    chk_seq("single_hs", hs_msg, '{2});
    if (hs_cyc.size() == 1) chk("single_latency", hs_cyc[0], 2);
    chk_seq("single_done", done_log, '{2});

    // Simultaneous request and response: response goes first.
    do_reset();
    cycle(1, RETRAIN_REQ, 1, RETRAIN_RSP, 1);
    idle(8, 1);
    chk_seq("simul_hs", hs_msg, '{12, 11});
    if (hs_cyc.size() == 2) chk("simul_gap", hs_cyc[1] - hs_cyc[0], 3);
    chk_seq("simul_done", done_log, '{2, 1});

    // Starvation guard: request slips in after two responses.
    do_reset();
    cycle(1, ACTIVE_REQ, 1, ACTIVE_RSP, 1);
    cycle(0, 0, 1, LINKRESET_RSP, 1);
    cycle(0, 0, 1, LINKERROR_RSP, 1);
    idle(14, 1);
    chk_seq("starve_hs", hs_msg, '{2, 8, 1, 10});
    chk_seq("starve_done", done_log, '{2, 2, 1, 2});

    // Backpressure: message held while the link stalls.
    do_reset();
    cycle(1, DISABLE_REQ, 0, 0, 0);
    idle(10, 0);
    chk("bp_msg_held", o_sb_msg, 13);
    chk("bp_no_done", done_log.size(), 0);
    idle(4, 1);
    chk_seq("bp_hs", hs_msg, '{13});
    chk_seq("bp_done", done_log, '{1});

    // Overflow on the response queue.
    do_reset();
    cycle(0, 0, 1, ACTIVE_RSP, 0);
    cycle(0, 0, 1, LINKRESET_RSP, 0);
    cycle(0, 0, 1, LINKERROR_RSP, 0);
    chk("ovf_flag", o_overflow, 1);
    idle(3, 0);
    idle(10, 1);
    chk_seq("ovf_hs", hs_msg, '{2, 8});
    chk("ovf_sticky", o_overflow, 1);

    // Asynchronous reset in the middle of SEND.
    do_reset();
    cycle(1, LINKRESET_REQ, 0, 0, 0);
    cycle(1, LINKERROR_REQ, 0, 0, 0);
    cycle(1, DISABLE_REQ, 0, 0, 0);
    chk("mid_pre_ovf", o_overflow, 1);
    chk("mid_pre_valid", o_sb_valid, 1);
    #2 sys_rst = 1'b0;
    #1;
    chk("mid_valid",    o_sb_valid, 0);
    chk("mid_msg",      o_sb_msg,   0);
    chk("mid_req_done", o_req_done, 0);
    chk("mid_busy",     o_tx_busy,  0);
    chk("mid_overflow", o_overflow, 0);
    model_reset();
    @(negedge lclk);
    sys_rst = 1'b1;
    clear_logs();
    idle(8, 1);
    chk("mid_no_hs", hs_msg.size(), 0);
    chk("mid_no_done", done_log.size(), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 30, req_tab[$urandom_range(0, 5)],
            $urandom_range(0, 99) < 30, rsp_tab[$urandom_range(0, 5)],
            $urandom_range(0, 99) < 70);
    end
    idle(24, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
